// File: rtl/display_7seg_pkg.sv
// Shared constants, segment codes, FSM states and the BCD adjust step
// for the sequential 7-segment decimal display controller.
package display_7seg_pkg;

    localparam int NUM_DIGITOS = 8;
    localparam int BCD_DIGITOS = 10;
    localparam int LARGURA     = 32;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        OCIOSO,
        DESLOCA,
        ESCREVE
    } estado_t;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [4*BCD_DIGITOS-1:0] ajusta_bcd(input logic [4*BCD_DIGITOS-1:0] bcd);
        logic [4*BCD_DIGITOS-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITOS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module bcd_to_7seg
    import display_7seg_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] segmentos
);

    // Pure lookup; the caller registers the result
    always_comb begin
        case (digito)
            4'd0:    segmentos = SEG_0;
            4'd1:    segmentos = SEG_1;
            4'd2:    segmentos = SEG_2;
            4'd3:    segmentos = SEG_3;
            4'd4:    segmentos = SEG_4;
            4'd5:    segmentos = SEG_5;
            4'd6:    segmentos = SEG_6;
            4'd7:    segmentos = SEG_7;
            4'd8:    segmentos = SEG_8;
            4'd9:    segmentos = SEG_9;
            default: segmentos = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_7seg_controller.sv
// Sequential binary-to-decimal display path: selects a 32-bit value,
// converts it with a bit-serial double-dabble loop and updates eight
// registered 7-segment displays only once the conversion is complete.
//
// state   | meaning
// OCIOSO  | idle, waiting for atualizar, refresh tick or pending request
// DESLOCA | 32 double-dabble shift steps, displays hold old image
// ESCREVE | load displays and estouro, pulse pronto
module display_7seg_controller
    import display_7seg_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000,
    parameter bit BLANK_ZEROS    = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] valor_a,
    input  logic [LARGURA-1:0] valor_b,
    input  logic               seletor,
    input  logic               atualizar,
    output logic               ocupado,
    output logic               pronto,
    output logic               estouro,
    output logic [6:0]         display0,
    output logic [6:0]         display1,
    output logic [6:0]         display2,
    output logic [6:0]         display3,
    output logic [6:0]         display4,
    output logic [6:0]         display5,
    output logic [6:0]         display6,
    output logic [6:0]         display7
);

    localparam bit          REFRESH_EN = (REFRESH_CYCLES > 0);
    localparam logic [31:0] ULTIMO     = 32'(REFRESH_EN ? REFRESH_CYCLES - 1 : 0);

    estado_t                    estado;
    logic [LARGURA-1:0]         operando;
    logic [4*BCD_DIGITOS-1:0]   bcd;
    logic [4:0]                 bit_cnt;
    logic                       pendente;
    logic [31:0]                cnt_refresh;
    logic                       tick;
    logic                       gatilho;
    logic [6:0]                 disp      [NUM_DIGITOS];
    logic [6:0]                 seg_bruto [NUM_DIGITOS];
    logic [6:0]                 seg_novo  [NUM_DIGITOS];
    logic                       zeros_acima;

    assign tick    = REFRESH_EN && (cnt_refresh == ULTIMO);
    assign gatilho = atualizar || tick;

    // Free-running refresh counter, wraps at REFRESH_CYCLES-1
    always_ff @(posedge clock) begin
        if (reset || !REFRESH_EN || tick)
            cnt_refresh <= '0;
        else
            cnt_refresh <= cnt_refresh + 32'd1;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITOS; g++) begin : g_dec
            bcd_to_7seg u_dec (
                .digito    (bcd[4*g +: 4]),
                .segmentos (seg_bruto[g])
            );
        end
    endgenerate

    // Leading-zero blanking over digits 7..1; digit 0 always shows a value
    always_comb begin
        zeros_acima = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++)
            seg_novo[i] = seg_bruto[i];
        for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
            zeros_acima = zeros_acima && (bcd[4*i +: 4] == 4'd0);
            if (BLANK_ZEROS && zeros_acima)
                seg_novo[i] = SEG_BLANK;
        end
    end

    // Conversion FSM with registered displays and status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            operando <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            pendente <= 1'b0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            estouro  <= 1'b0;
            for (int i = 0; i < NUM_DIGITOS; i++)
                disp[i] <= (BLANK_ZEROS && i != 0) ? SEG_BLANK : SEG_0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (gatilho || pendente) begin
                        operando <= seletor ? valor_b : valor_a;
                        bcd      <= '0;
                        bit_cnt  <= '0;
                        pendente <= 1'b0;
                        ocupado  <= 1'b1;
                        estado   <= DESLOCA;
                    end
                end
                DESLOCA: begin
                    {bcd, operando} <= {ajusta_bcd(bcd), operando} << 1;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31)
                        estado <= ESCREVE;
                    if (gatilho)
                        pendente <= 1'b1;
                end
                ESCREVE: begin
                    for (int i = 0; i < NUM_DIGITOS; i++)
                        disp[i] <= seg_novo[i];
                    estouro <= |bcd[4*BCD_DIGITOS-1:4*NUM_DIGITOS];
                    pronto  <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                    if (gatilho)
                        pendente <= 1'b1;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign display0 = disp[0];
    assign display1 = disp[1];
    assign display2 = disp[2];
    assign display3 = disp[3];
    assign display4 = disp[4];
    assign display5 = disp[5];
    assign display6 = disp[6];
    assign display7 = disp[7];

endmodule

// File: tb/tb_display_7seg_controller.sv
// Directed bench for display_7seg_controller: three instances cover
// manual updates, auto-refresh and leading-zero blanking.
module tb_display_7seg_controller;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] valor_a, valor_b;
    logic        seletor;
    logic        atu0, atu1, atu2;
    logic        oc0, pr0, es0, oc1, pr1, es1, oc2, pr2, es2;
    logic [6:0]  d0 [8];
    logic [6:0]  d1 [8];
    logic [6:0]  d2 [8];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    display_7seg_controller #(.REFRESH_CYCLES(0), .BLANK_ZEROS(1'b0)) u0 (
        .clock(clock), .reset(reset), .valor_a(valor_a), .valor_b(valor_b),
        .seletor(seletor), .atualizar(atu0), .ocupado(oc0), .pronto(pr0), .estouro(es0),
        .display0(d0[0]), .display1(d0[1]), .display2(d0[2]), .display3(d0[3]),
        .display4(d0[4]), .display5(d0[5]), .display6(d0[6]), .display7(d0[7])
    );

    display_7seg_controller #(.REFRESH_CYCLES(50), .BLANK_ZEROS(1'b0)) u1 (
        .clock(clock), .reset(reset), .valor_a(valor_a), .valor_b(valor_b),
        .seletor(seletor), .atualizar(atu1), .ocupado(oc1), .pronto(pr1), .estouro(es1),
        .display0(d1[0]), .display1(d1[1]), .display2(d1[2]), .display3(d1[3]),
        .display4(d1[4]), .display5(d1[5]), .display6(d1[6]), .display7(d1[7])
    );

    display_7seg_controller #(.REFRESH_CYCLES(0), .BLANK_ZEROS(1'b1)) u2 (
        .clock(clock), .reset(reset), .valor_a(valor_a), .valor_b(valor_b),
        .seletor(seletor), .atualizar(atu2), .ocupado(oc2), .pronto(pr2), .estouro(es2),
        .display0(d2[0]), .display1(d2[1]), .display2(d2[2]), .display3(d2[3]),
        .display4(d2[4]), .display5(d2[5]), .display6(d2[6]), .display7(d2[7])
    );

    // Counts negedges until pronto of instance u, bounded; also counts
    // samples where ocupado was low before pronto arrived.
    task automatic wait_pronto(input int u, output int cyc, output int busy_bad);
        logic p, o;
        cyc = 0;
        busy_bad = 0;
        forever begin
            p = (u == 0) ? pr0 : (u == 1) ? pr1 : pr2;
            o = (u == 0) ? oc0 : (u == 1) ? oc1 : oc2;
            if (p === 1'b1 || cyc >= 150) break;
            if (o !== 1'b1) busy_bad++;
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        int act;
        reset = 1'b1; atu0 = 0; atu1 = 0; atu2 = 0;
        valor_a = '0; valor_b = '0; seletor = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (d0[i] !== SEG_TAB[0]) begin
                tests_failed++;
                $display("FAIL reset_disp%0d: got %b expected %b", i, d0[i], SEG_TAB[0]);
            end
            tests_run++;
            if (d2[i] !== ((i == 0) ? SEG_TAB[0] : BLANK)) begin
                tests_failed++;
                $display("FAIL reset_blank_disp%0d: got %b expected %b", i, d2[i],
                         (i == 0) ? SEG_TAB[0] : BLANK);
            end
        end
        tests_run++;
        if ({oc0, pr0, es0} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {oc0, pr0, es0});
        end
        act = 0;
        repeat (200) begin
            @(negedge clock);
            if (oc0 !== 1'b0 || pr0 !== 1'b0 || oc2 !== 1'b0 || pr2 !== 1'b0) act++;
        end
        tests_run++;
        if (act != 0) begin
            tests_failed++;
            $display("FAIL idle_no_refresh: got %0d active cycles expected 0", act);
        end
    endtask

    task automatic test_basic();
        int cyc, bad;
        valor_a = 32'd12345678; seletor = 1'b0;
        atu0 = 1'b1;
        @(negedge clock);
        atu0 = 1'b0;
        tests_run++;
        if (oc0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy_start: got %b expected 1", oc0);
        end
        wait_pronto(0, cyc, bad);
        tests_run++;
        if (cyc != 33 || bad != 0) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles (%0d idle) expected 33 (0)", cyc, bad);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (d0[i] !== SEG_TAB[8-i]) begin
                tests_failed++;
                $display("FAIL basic_disp%0d: got %b expected %b", i, d0[i], SEG_TAB[8-i]);
            end
        end
        tests_run++;
        if (es0 !== 1'b0 || oc0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_flags: got estouro=%b ocupado=%b expected 0 0", es0, oc0);
        end
        @(negedge clock);
        tests_run++;
        if (pr0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_pronto_width: got %b expected 0", pr0);
        end
    endtask

    task automatic test_max();
        int cyc, bad;
        logic [31:0] exp_bcd;
        exp_bcd = 32'h94967295;
        valor_b = 32'hFFFFFFFF; seletor = 1'b1; valor_a = 32'd3;
        atu0 = 1'b1;
        @(negedge clock);
        atu0 = 1'b0;
        wait_pronto(0, cyc, bad);
        tests_run++;
        if (cyc != 33) begin
            tests_failed++;
            $display("FAIL max_latency: got %0d expected 33", cyc);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (d0[i] !== SEG_TAB[exp_bcd[4*i +: 4]]) begin
                tests_failed++;
                $display("FAIL max_disp%0d: got %b expected %b", i, d0[i], SEG_TAB[exp_bcd[4*i +: 4]]);
            end
        end
        tests_run++;
        if (es0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL max_estouro: got %b expected 1", es0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bad, extra;
        @(negedge clock);
        seletor = 1'b0; valor_a = 32'd5;
        atu0 = 1'b1;
        @(negedge clock);
        atu0 = 1'b0;
        repeat (5) @(negedge clock);
        valor_a = 32'd42;
        atu0 = 1'b1;
        @(negedge clock);
        atu0 = 1'b0;
        repeat (2) @(negedge clock);
        atu0 = 1'b1;
        @(negedge clock);
        atu0 = 1'b0;
        wait_pronto(0, cyc, bad);
        tests_run++;
        if (pr0 !== 1'b1 || d0[0] !== SEG_TAB[5] || d0[1] !== SEG_TAB[0] || es0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: got pronto=%b d0=%b d1=%b estouro=%b expected 1 %b %b 0",
                     pr0, d0[0], d0[1], es0, SEG_TAB[5], SEG_TAB[0]);
        end
        @(negedge clock);
        tests_run++;
        if (oc0 !== 1'b1 || pr0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_restart: got ocupado=%b pronto=%b expected 1 0", oc0, pr0);
        end
        wait_pronto(0, cyc, bad);
        tests_run++;
        if (cyc != 33 || bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_second_latency: got %0d (%0d idle) expected 33 (0)", cyc, bad);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (d0[i] !== ((i == 1) ? SEG_TAB[4] : (i == 0) ? SEG_TAB[2] : SEG_TAB[0])) begin
                tests_failed++;
                $display("FAIL b2b_disp%0d: got %b", i, d0[i]);
            end
        end
        extra = 0;
        repeat (60) begin
            @(negedge clock);
            if (pr0 === 1'b1) extra++;
        end
        tests_run++;
        if (extra != 0 || oc0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_extra_pronto: got %0d pulses ocupado=%b expected 0 0", extra, oc0);
        end
    endtask

    task automatic test_refresh();
        int cyc, bad, n;
        bit seen;
        seletor = 1'b0; valor_a = 32'd7;
        wait_pronto(1, cyc, bad);
        @(negedge clock);
        wait_pronto(1, cyc, bad);
        tests_run++;
        if (cyc != 49 || pr1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL refresh_period: got %0d expected 49 (pronto=%b)", cyc, pr1);
        end
        tests_run++;
        if (d1[0] !== SEG_TAB[7] || d1[1] !== SEG_TAB[0]) begin
            tests_failed++;
            $display("FAIL refresh_value7: got %b %b expected %b %b", d1[1], d1[0], SEG_TAB[0], SEG_TAB[7]);
        end
        valor_a = 32'd99;
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clock);
            n++;
            if (d1[0] === SEG_TAB[9] && d1[1] === SEG_TAB[9]) seen = 1'b1;
        end
        tests_run++;
        if (!seen || n > 84) begin
            tests_failed++;
            $display("FAIL refresh_value99: got seen=%0d after %0d cycles expected within 84", seen, n);
        end
    endtask

    task automatic test_blank();
        int cyc, bad, pulses;
        logic [6:0] exp_img [8];
        valor_a = 32'd0; seletor = 1'b0;
        atu2 = 1'b1;
        @(negedge clock);
        atu2 = 1'b0;
        wait_pronto(2, cyc, bad);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (d2[i] !== ((i == 0) ? SEG_TAB[0] : BLANK)) begin
                tests_failed++;
                $display("FAIL blank_zero_disp%0d: got %b", i, d2[i]);
            end
        end
        @(negedge clock);
        valor_a = 32'd1002;
        atu2 = 1'b1;
        @(negedge clock);
        atu2 = 1'b0;
        wait_pronto(2, cyc, bad);
        exp_img = '{SEG_TAB[2], SEG_TAB[0], SEG_TAB[0], SEG_TAB[1], BLANK, BLANK, BLANK, BLANK};
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (d2[i] !== exp_img[i]) begin
                tests_failed++;
                $display("FAIL blank_1002_disp%0d: got %b expected %b", i, d2[i], exp_img[i]);
            end
        end
        @(negedge clock);
        valor_a = 32'd87654321;
        atu2 = 1'b1;
        @(negedge clock);
        atu2 = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (d2[i] !== ((i == 0) ? SEG_TAB[0] : BLANK)) begin
                tests_failed++;
                $display("FAIL abort_disp%0d: got %b", i, d2[i]);
            end
        end
        pulses = 0;
        repeat (60) begin
            @(negedge clock);
            if (pr2 === 1'b1 || oc2 === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL abort_no_pronto: got %0d active cycles expected 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_refresh();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
